fifo_dispatcher: RTL and testbench
==================================

// Module: fifo_dispatcher
// PURPOSE
//  Read-side counterpart of the multi-writer FIFO arbiter. Pops words from the shared FIFO and
//  hands each word to exactly one of NUM_READERS reader modules. Readers request with a req line;
//  the dispatcher grants requesters round-robin and delivers each word with a one-cycle valid pulse.
//  Sits between the FIFO read port (re/rdata/empty) and the reader modules.
// PARAMETERS
//  NUM_READERS  2   number of reader modules (>=2, need not be a power of two)
//  DATA_W       8   FIFO word width
//  COUNT_W      16  width of delivered-word counter o_words
// PORTS
//  i_clk      in   1                      single clock, all logic on posedge
//  i_reset    in   1                      asynchronous, active-high reset
//  i_empty    in   1                      FIFO empty flag
//  i_rdata    in   DATA_W                 FIFO read data, valid the cycle after o_re sampled
//  o_re       out  1                      FIFO read strobe, one-cycle pulse
//  i_req      in   NUM_READERS            reader n wants a word; held high until served
//  o_valid    out  NUM_READERS            one-hot, one-cycle delivery pulse to reader n
//  o_data     out  DATA_W                 delivered word, shared by all readers
//  o_words    out  COUNT_W                total words delivered, wraps modulo 2^COUNT_W
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, o_re=0, o_valid=0, o_data=0, o_words=0, rr_last=NUM_READERS-1.
//  FSM: IDLE -> READ -> LOAD -> DELIVER -> IDLE; all outputs registered.
//   IDLE: at an edge where !i_empty && |i_req: grant <= first requester searching rr_last+1,
//         rr_last+2, ... modulo NUM_READERS; o_re <= 1; -> READ. Otherwise stay, o_re=0.
//   READ: o_re high this cycle (FIFO pops on this edge); o_re <= 0; -> LOAD.
//   LOAD: i_rdata valid; o_data <= i_rdata; o_valid[grant] <= 1; -> DELIVER.
//   DELIVER: o_valid high this cycle; o_valid <= 0; rr_last <= grant; o_words <= o_words+1; -> IDLE.
//  Latency: IDLE decision edge E -> o_re high cycle E+1 -> o_valid/o_data valid cycle E+3.
//  Throughput: max one word per 4 cycles; next o_re no earlier than cycle E+5.
//  Grant is latched at the IDLE decision; i_req changes afterwards do not alter target. A reader
//  that drops i_req after being granted still receives the pulse (readers must accept it).
//  o_data holds its last value until the next LOAD; o_valid never has more than one bit set.
//  i_empty checked only in IDLE; FIFO never read when empty. i_req==0 -> no read even if non-empty.
//  Only one word in flight; no read issued in READ/LOAD/DELIVER.
//  Round-robin: a reader served last has lowest priority next; a lone requester is served every time.
//  o_words wraps 2^COUNT_W-1 -> 0 with no flag.
//  Reset mid-operation: word already popped (READ/LOAD) is discarded, no o_valid pulse, o_words
//  not incremented; documented data loss.
// TESTING
//  T1 reset, i_empty=1, i_req=2'b11 for 20 cycles -> o_re and o_valid stay 0, o_words=0.
//  T2 FIFO holds 0xA5, i_req=2'b10 -> o_re pulse 1 cycle after decision, o_valid=2'b10 with
//     o_data=0xA5 exactly 2 cycles after o_re, o_words=1, FIFO empty afterwards.
//  T3 FIFO holds 0x01..0x04, i_req=2'b11 held -> readers 0,1,0,1 receive 0x01,0x02,0x03,0x04,
//     o_valid pulses 4 cycles apart, o_words=4.
//  T4 NUM_READERS=3, i_req=3'b101 -> grant order 0,2,0,2; reader 1 never pulsed.
//  T5 reader 0 granted, drops i_req during READ -> o_valid=2'b01 still pulses with the popped word.
//  T6 assert i_reset in LOAD -> no o_valid pulse, o_words=0, o_re=0; COUNT_W=2, 5 words
//     delivered afterwards -> o_words=1 (wrap).

Source files
------------

// File: rtl/fifo_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : fifo_dispatcher
// Description : Pops words from a shared FIFO and delivers each one to a
//               single reader. Readers are granted round-robin. Each word
//               arrives as a one-cycle, one-hot valid pulse on a shared data
//               bus. Only one word is in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_dispatcher #(
    parameter int NUM_READERS = 2,
    parameter int DATA_W      = 8,
    parameter int COUNT_W     = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_empty,
    input  logic [DATA_W-1:0]      i_rdata,
    output logic                   o_re,
    input  logic [NUM_READERS-1:0] i_req,
    output logic [NUM_READERS-1:0] o_valid,
    output logic [DATA_W-1:0]      o_data,
    output logic [COUNT_W-1:0]     o_words
);

    localparam int C_RR_W = (NUM_READERS > 1) ? $clog2(NUM_READERS) : 1;
    localparam logic [C_RR_W-1:0] C_RR_RESET = C_RR_W'(NUM_READERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_LOAD    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     re_q, re_d;
    logic [NUM_READERS-1:0]   valid_q, valid_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic [COUNT_W-1:0]       words_q, words_d;
    logic [C_RR_W-1:0]        rr_last_q, rr_last_d;
    logic [C_RR_W-1:0]        grant_q, grant_d;

    logic [C_RR_W-1:0]        w_pick;
    logic                     w_found;
    int                       w_idx;

    // Round-robin search: first requester after the last-served reader, wrapping.
    always_comb begin
        w_pick  = rr_last_q;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_READERS; k++) begin
            w_idx = int'(rr_last_q) + k;
            if (w_idx >= NUM_READERS) begin
                w_idx = w_idx - NUM_READERS;
            end
            if (!w_found && i_req[C_RR_W'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = C_RR_W'(w_idx);
            end
        end
    end

    // Next-state and registered-output logic for the four-phase dispatch cycle.
    always_comb begin
        state_d   = state_q;
        re_d      = 1'b0;
        valid_d   = '0;
        data_d    = data_q;
        words_d   = words_q;
        rr_last_d = rr_last_q;
        grant_d   = grant_q;
        case (state_q)
            ST_IDLE: begin
                // The target is frozen here; later request changes are ignored.
                if (!i_empty && w_found) begin
                    grant_d = w_pick;
                    re_d    = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                data_d = i_rdata;
                for (int i = 0; i < NUM_READERS; i++) begin
                    valid_d[i] = (grant_q == C_RR_W'(i));
                end
                state_d = ST_DELIVER;
            end
            ST_DELIVER: begin
                // Priority rotates only once the word has actually been handed over.
                rr_last_d = grant_q;
                words_d   = words_q + COUNT_W'(1);
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops any word already popped but not yet delivered.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            re_q      <= 1'b0;
            valid_q   <= '0;
            data_q    <= '0;
            words_q   <= '0;
            rr_last_q <= C_RR_RESET;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            re_q      <= re_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            words_q   <= words_d;
            rr_last_q <= rr_last_d;
            grant_q   <= grant_d;
        end
    end

    assign o_re    = re_q;
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_words = words_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_dispatcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fifo_dispatcher
// Description : Self-checking bench for fifo_dispatcher. Two instances: a
//               two-reader one with a wide counter and a three-reader one with
//               a 2-bit counter. Expected deliveries go into per-instance
//               queues when words are pushed and are popped on each valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_dispatcher;

    typedef struct {
        logic [2:0] v;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic       empty_a, re_a, empty_b, re_b;
    logic [7:0] rdata_a, data_a, rdata_b, data_b;
    logic [1:0] req_a, valid_a;
    logic [2:0] req_b, valid_b;
    logic [15:0] words_a;
    logic [1:0]  words_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    fifo_dispatcher #(.NUM_READERS(2), .DATA_W(8), .COUNT_W(16)) dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_empty(empty_a), .i_rdata(rdata_a),
        .o_re(re_a), .i_req(req_a), .o_valid(valid_a), .o_data(data_a),
        .o_words(words_a)
    );

    fifo_dispatcher #(.NUM_READERS(3), .DATA_W(8), .COUNT_W(2)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_empty(empty_b), .i_rdata(rdata_b),
        .o_re(re_b), .i_req(req_b), .o_valid(valid_b), .o_data(data_b),
        .o_words(words_b)
    );

    // FIFO models: data appears the cycle after the read strobe is sampled.
    logic [7:0] mem_a [0:63];
    logic [7:0] mem_b [0:63];
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
    assign empty_a = (wr_a == rd_a);
    assign empty_b = (wr_b == rd_b);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (re_a && (wr_a != rd_a)) begin
            rdata_a <= mem_a[rd_a[5:0]];
            rd_a    <= rd_a + 1;
        end
        if (re_b && (wr_b != rd_b)) begin
            rdata_b <= mem_b[rd_b[5:0]];
            rd_b    <= rd_b + 1;
        end
    end

    exp_t sb_a[$];
    exp_t sb_b[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input bit sel_b, input logic [7:0] d, input logic [2:0] v, input bit expect_it);
        exp_t e;
        e.v = v;
        e.d = d;
        if (sel_b) begin
            mem_b[wr_b[5:0]] = d;
            wr_b = wr_b + 1;
            if (expect_it) sb_b.push_back(e);
        end else begin
            mem_a[wr_a[5:0]] = d;
            wr_a = wr_a + 1;
            if (expect_it) sb_a.push_back(e);
        end
    endtask

    // Monitors: strobe shape, latency, one-hot, and scoreboard comparison.
    int   n_re_a = 0, n_del_a = 0, re_cyc_a = 0;
    int   n_re_b = 0, n_del_b = 0, re_cyc_b = 0, n_r1_b = 0;
    logic re_prev_a = 1'b0, re_prev_b = 1'b0;
    int   del_cyc_a [0:31];
    exp_t ea, eb;

    always @(negedge clk) begin
        if (re_a) begin
            n_re_a++;
            re_cyc_a = cyc;
            check_eq("re_pulse_a", re_prev_a, 1'b0);
            check_eq("re_nonempty_a", empty_a, 1'b0);
        end
        if (valid_a != 2'b00) begin
            check_eq("onehot_a", $countones(valid_a), 1);
            check_eq("latency_a", cyc - re_cyc_a, 2);
            check_eq("sb_a_pending", sb_a.size() > 0, 1'b1);
            if (sb_a.size() > 0) begin
                ea = sb_a.pop_front();
                check_eq("reader_a", valid_a, ea.v);
                check_eq("data_a", data_a, ea.d);
            end
            if (n_del_a < 32) del_cyc_a[n_del_a] = cyc;
            n_del_a++;
        end
        re_prev_a = re_a;

        if (re_b) begin
            n_re_b++;
            re_cyc_b = cyc;
            check_eq("re_pulse_b", re_prev_b, 1'b0);
            check_eq("re_nonempty_b", empty_b, 1'b0);
        end
        if (valid_b != 3'b000) begin
            if (valid_b[1]) n_r1_b++;
            check_eq("onehot_b", $countones(valid_b), 1);
            check_eq("latency_b", cyc - re_cyc_b, 2);
            check_eq("sb_b_pending", sb_b.size() > 0, 1'b1);
            if (sb_b.size() > 0) begin
                eb = sb_b.pop_front();
                check_eq("reader_b", valid_b, eb.v);
                check_eq("data_b", data_b, eb.d);
            end
            n_del_b++;
        end
        re_prev_b = re_b;
    end

    // Bounded wait for a delivery count; the final compare doubles as the timeout check.
    task automatic wait_del(input bit sel_b, input int n, input string tag);
        int budget = 200;
        while (((sel_b ? n_del_b : n_del_a) < n) && (budget > 0)) begin
            @(negedge clk);
            budget--;
        end
        check_eq(tag, sel_b ? n_del_b : n_del_a, n);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int base_re;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        req_a = 2'b00;
        req_b = 3'b000;
        repeat (3) @(negedge clk);
        check_eq("rst_re_a", re_a, 1'b0);
        check_eq("rst_valid_a", valid_a, 2'b00);
        check_eq("rst_data_a", data_a, 8'h00);
        check_eq("rst_words_a", words_a, 16'd0);
        check_eq("rst_valid_b", valid_b, 3'b000);
        check_eq("rst_words_b", words_b, 2'd0);

        // T1: requests with an empty FIFO never read or deliver.
        req_a = 2'b11;
        req_b = 3'b111;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("t1_no_re", n_re_a, 0);
        check_eq("t1_no_valid", n_del_a, 0);
        check_eq("t1_words", words_a, 16'd0);
        req_a = 2'b00;
        req_b = 3'b000;

        // T2: single word to reader 1 with exact cycle timing.
        @(negedge clk);
        req_a = 2'b10;
        push(1'b0, 8'hA5, 3'b010, 1'b1);
        @(posedge clk); #1;
        check_eq("t2_re_high", re_a, 1'b1);
        @(posedge clk); #1;
        check_eq("t2_re_low", re_a, 1'b0);
        @(posedge clk); #1;
        check_eq("t2_valid", valid_a, 2'b10);
        check_eq("t2_data", data_a, 8'hA5);
        @(posedge clk); #1;
        check_eq("t2_valid_clear", valid_a, 2'b00);
        wait_del(1'b0, 1, "t2_count");
        req_a = 2'b00;
        repeat (2) @(negedge clk);
        check_eq("t2_words", words_a, 16'd1);
        check_eq("t2_fifo_empty", empty_a, 1'b1);

        // T3: both readers requesting alternate, one word every four cycles.
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        req_a = 2'b11;
        push(1'b0, 8'h01, 3'b001, 1'b1);
        push(1'b0, 8'h02, 3'b010, 1'b1);
        push(1'b0, 8'h03, 3'b001, 1'b1);
        push(1'b0, 8'h04, 3'b010, 1'b1);
        wait_del(1'b0, 5, "t3_count");
        req_a = 2'b00;
        repeat (2) @(negedge clk);
        check_eq("t3_words", words_a, 16'd4);
        check_eq("t3_data_hold", data_a, 8'h04);
        for (int i = 2; i <= 4; i++) begin
            check_eq("t3_spacing", del_cyc_a[i] - del_cyc_a[i-1], 4);
        end

        // Non-empty FIFO with no request must not be read.
        base_re = n_re_a;
        push(1'b0, 8'h77, 3'b010, 1'b1);
        repeat (10) @(negedge clk);
        check_eq("noreq_no_re", n_re_a, base_re);
        req_a = 2'b10;
        wait_del(1'b0, 6, "noreq_count");
        req_a = 2'b00;

        // T5: reader 0 drops its request after the grant and still receives the word.
        @(negedge clk);
        req_a = 2'b01;
        push(1'b0, 8'h5C, 3'b001, 1'b1);
        @(negedge clk);
        check_eq("t5_in_read", re_a, 1'b1);
        req_a = 2'b00;
        wait_del(1'b0, 7, "t5_count");
        repeat (2) @(negedge clk);
        check_eq("t5_words", words_a, 16'd6);

        // T4: three readers, readers 0 and 2 requesting; reader 1 never served.
        @(negedge clk);
        req_b = 3'b101;
        push(1'b1, 8'h10, 3'b001, 1'b1);
        push(1'b1, 8'h11, 3'b100, 1'b1);
        push(1'b1, 8'h12, 3'b001, 1'b1);
        push(1'b1, 8'h13, 3'b100, 1'b1);
        wait_del(1'b1, 4, "t4_count");
        req_b = 3'b000;
        repeat (2) @(negedge clk);
        check_eq("t4_reader1_idle", n_r1_b, 0);
        check_eq("t4_words_wrap", words_b, 2'd0);

        // T6: reset during LOAD discards the popped word; then counter wrap.
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        req_b = 3'b010;
        push(1'b1, 8'hEE, 3'b010, 1'b0);
        @(negedge clk);
        check_eq("t6_in_read", re_b, 1'b1);
        @(negedge clk);
        check_eq("t6_in_load", re_b, 1'b0);
        rst_b = 1'b1;
        #1;
        check_eq("t6_rst_valid", valid_b, 3'b000);
        check_eq("t6_rst_words", words_b, 2'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("t6_no_delivery", n_del_b, 4);
        check_eq("t6_re_idle", re_b, 1'b0);
        check_eq("t6_words", words_b, 2'd0);
        check_eq("t6_fifo_empty", empty_b, 1'b1);
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 8'(8'h20 + i), 3'b010, 1'b1);
        end
        wait_del(1'b1, 9, "t6_count");
        req_b = 3'b000;
        repeat (2) @(negedge clk);
        check_eq("t6_words_wrap", words_b, 2'd1);

        check_eq("sb_a_drained", sb_a.size(), 0);
        check_eq("sb_b_drained", sb_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
